// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares one data-memory port between the CPU MEM stage and an
//            external loader/debug requester, with starvation-bounded ext.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } rsp_state_t;

    rsp_state_t r_state;
    rsp_state_t w_state_nxt;
    logic [3:0] r_wait_cnt;
    logic       w_creq;
    logic       w_ereq;
    logic       w_gnt_we;

    assign w_creq = cpu_req & enable & ~rst;
    assign w_ereq = ext_req & ~rst;

    // CPU wins by default; ext is forced through once it has waited MAX_WAIT cycles.
    assign ext_gnt   = w_ereq & (~w_creq | (r_wait_cnt == c_MAX_WAIT));
    assign cpu_gnt   = w_creq & ~ext_gnt;
    assign cpu_stall = w_creq & ~cpu_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        w_gnt_we  = 1'b0;
        if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            w_gnt_we  = ext_we;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            w_gnt_we  = cpu_we;
        end
    end

    assign mem_wen = (cpu_gnt | ext_gnt) & w_gnt_we;
    assign mem_ren = (cpu_gnt | ext_gnt) & ~w_gnt_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (!w_ereq || ext_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt < c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (cpu_gnt && !cpu_we) begin
            w_state_nxt = CPU_RD;
        end else if (ext_gnt && !ext_we) begin
            w_state_nxt = EXT_RD;
        end
    end

    // Masking with rst drops a read whose response would land in the reset cycle.
    assign cpu_rvalid = (r_state == CPU_RD) & ~rst;
    assign ext_rvalid = (r_state == EXT_RD) & ~rst;
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Single-port arbiter that shares the 64-bit data memory (sram_BW64 internal port) between the CPU MEM-stage access and an external loader/debug requester. CPU has default priority; a saturating wait counter guarantees the external requester service within a bounded number of cycles by stalling the CPU for one cycle. A small response FSM tracks which requester owns the read data returning one cycle after each read grant.

## Interface
- DATA_W, 64: data width of both requesters and the memory
- ADDR_W, 64: address width of both requesters and the memory
- MAX_WAIT, 4: consecutive denied ext cycles before ext is forced through; range 1..15
- clk  in  1  main clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- enable  in  1  CPU execution enable; when low, cpu_req is ignored (treated as 0)
- cpu_req  in  1  CPU MEM-stage access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & enable & ~cpu_gnt; pipeline must hold
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a CPU read grant)
- cpu_rdata  out  DATA_W  equals mem_rdata
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external request, same meaning as CPU fields
- ext_gnt  out  1  ext access issued this cycle
- ext_rvalid  out  1  ext_rdata valid (cycle after an ext read grant)
- ext_rdata  out  DATA_W  equals mem_rdata
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to memory; 0 when no grant
- mem_wen, mem_ren  out  1  to memory; at most one high; both 0 when no grant
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_ren

## Operation
- Effective CPU request: creq = cpu_req & enable & ~rst. Effective ext request: ereq = ext_req & ~rst.
- Grant (combinational, same cycle): ext_gnt = ereq & (~creq | wait_cnt == MAX_WAIT); cpu_gnt = creq & ~ext_gnt. Never both high.
- Memory mux: granted requester's addr/wdata drive mem_addr/mem_wdata; mem_wen = gnt & we, mem_ren = gnt & ~we.
- wait_cnt (4 bits, reset 0): if ~ereq or ext_gnt -> 0; else if wait_cnt < MAX_WAIT -> +1 (saturates at MAX_WAIT).
- Response FSM, states IDLE, CPU_RD, EXT_RD, next state from the current cycle's grants: cpu_gnt & ~cpu_we -> CPU_RD; ext_gnt & ~ext_we -> EXT_RD; otherwise IDLE. Any state may move to any state each cycle (back-to-back reads supported).
- cpu_rvalid = (state == CPU_RD); ext_rvalid = (state == EXT_RD). Writes produce no rvalid.
- Requesters must hold req/we/addr/wdata stable while not granted; the arbiter does not latch requests.

## Timing
- Grant latency: 0 cycles (same cycle as req when selected). Write commits at the rising edge ending the grant cycle.
- Read latency: data and rvalid exactly 1 cycle after grant; no backpressure on responses.
- Worst-case ext wait with continuous CPU traffic: MAX_WAIT denied cycles, granted on cycle MAX_WAIT+1; CPU stalled exactly that one cycle.
- Reset values: state IDLE, wait_cnt 0, cpu_rvalid = ext_rvalid = 0; during rst all grants, mem_wen, mem_ren, cpu_stall are 0.
- Reset mid-read: a read granted in the cycle before rst asserts is dropped; rvalid is 0 in the rst cycle and the cycle after.
- enable low: CPU never granted, cpu_stall 0, ext served every requested cycle; wait_cnt stays 0.
- ext_req deasserted before grant: wait_cnt clears next cycle; no partial access.

## Test plan
- Reset: rst=1 two cycles with cpu_req=ext_req=1 -> cpu_gnt=ext_gnt=mem_wen=mem_ren=0, both rvalid 0; after release cpu_gnt=1 first cycle.
- CPU read only: cpu_req=1, cpu_we=0, cpu_addr=0x10, memory holds 0xDEADBEEF at 0x10 -> cpu_gnt=1, mem_ren=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- Contention, MAX_WAIT=4: cpu_req and ext_req held 12 cycles -> ext_gnt on cycles 5 and 10 only, cpu_stall=1 on exactly those cycles, wait_cnt sequence 0,1,2,3,4,0,1,...
- Ext write while CPU idle: ext_we=1, ext_addr=0x8, ext_wdata=0x55 -> ext_gnt same cycle, mem_wen=1, no rvalid; CPU read of 0x8 afterwards returns 0x55.
- Back-to-back reads: CPU read 0x0 then ext read (forced) next cycle -> cpu_rvalid then ext_rvalid on consecutive cycles, each with its own address's data.
- enable=0 with cpu_req=1 and ext_req=1 -> ext_gnt=1 every cycle, cpu_gnt=0, cpu_stall=0; rst asserted the cycle after an ext read grant -> ext_rvalid stays 0.
